// File: rtl/sev_seg_pkg.sv
// Shared types and helpers for the scanned 7-segment display driver.
package sev_seg_pkg;

    localparam int N_DIGITS_DEFAULT = 4;

    typedef logic [3:0] nibble_t;

    typedef enum logic {
        IDLE,
        PENDING
    } load_state_t;

    // Active-low anode pattern with only the bit at 'index' pulled low.
    function automatic logic [31:0] onehot_n(input int unsigned index);
        return ~(32'd1 << index);
    endfunction

endpackage

// File: rtl/sev_seg_scan_mux_refresh_prescaler.sv
// Free-running divider that flags the last cycle of every REFRESH_DIV-cycle slot.
module refresh_prescaler #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    output logic slot_end
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign slot_end = (r_count == LAST);

endmodule

// File: rtl/sev_seg_scan_mux.sv
// Scan driver for a multi-digit common-anode display; new values land only on frame boundaries.
module sev_seg_scan_mux
    import sev_seg_pkg::*;
#(
    parameter int N_DIGITS    = N_DIGITS_DEFAULT,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*N_DIGITS-1:0]   value_in,
    input  logic                    load,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic                    blank_lz,
    output logic [3:0]              digit_nibble,
    output logic [N_DIGITS-1:0]     anode_n,
    output logic                    dp_n,
    output logic                    load_ack,
    output logic                    frame_tick
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

    logic                   w_slot_end;
    logic                   w_frame_end;
    logic [IDX_W-1:0]       r_index;
    load_state_t            r_state;
    logic [4*N_DIGITS-1:0]  r_staging;
    logic [4*N_DIGITS-1:0]  r_display;
    logic                   r_load_ack;

    nibble_t                w_nibble;
    logic                   w_dp;
    logic                   w_lz_blank;
    logic [N_DIGITS-1:0]    w_anode;

    nibble_t                r_digit_nibble;
    logic [N_DIGITS-1:0]    r_anode_n;
    logic                   r_dp_n;
    logic                   r_frame_tick;

    refresh_prescaler #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .slot_end (w_slot_end)
    );

    assign w_frame_end = w_slot_end && (r_index == LAST_IDX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_index <= '0;
        end else if (w_slot_end) begin
            r_index <= (r_index == LAST_IDX) ? '0 : r_index + IDX_W'(1);
        end
    end

    // A load arriving on the frame boundary bypasses staging so it is never held a full extra frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_staging  <= '0;
            r_display  <= '0;
            r_load_ack <= 1'b0;
        end else begin
            r_load_ack <= 1'b0;
            if (load && w_frame_end) begin
                r_staging  <= value_in;
                r_display  <= value_in;
                r_load_ack <= 1'b1;
                r_state    <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (load) begin
                            r_staging <= value_in;
                            r_state   <= PENDING;
                        end
                    end
                    PENDING: begin
                        if (w_frame_end) begin
                            r_display  <= r_staging;
                            r_load_ack <= 1'b1;
                            r_state    <= IDLE;
                        end else if (load) begin
                            r_staging <= value_in;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // A digit is blanked only when it and every more significant digit are zero.
    always_comb begin
        w_nibble   = '0;
        w_dp       = 1'b0;
        w_lz_blank = blank_lz && (r_index != '0);
        for (int i = 0; i < N_DIGITS; i++) begin
            if (IDX_W'(i) == r_index) begin
                w_nibble = r_display[4*i +: 4];
                w_dp     = dp_in[i];
            end
            if ((i >= int'(r_index)) && (r_display[4*i +: 4] != 4'h0)) begin
                w_lz_blank = 1'b0;
            end
        end
    end

    assign w_anode = N_DIGITS'(onehot_n(32'(r_index)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_digit_nibble <= '0;
            r_anode_n      <= '1;
            r_dp_n         <= 1'b1;
            r_frame_tick   <= 1'b0;
        end else begin
            r_digit_nibble <= w_nibble;
            r_anode_n      <= w_lz_blank ? '1 : w_anode;
            r_dp_n         <= ~w_dp;
            r_frame_tick   <= w_frame_end;
        end
    end

    assign digit_nibble = r_digit_nibble;
    assign anode_n      = r_anode_n;
    assign dp_n         = r_dp_n;
    assign load_ack     = r_load_ack;
    assign frame_tick   = r_frame_tick;

endmodule

// File: doc/sev_seg_scan_mux.md
Name: sev_seg_scan_mux

Overview:
- Time-multiplexed scan driver for a 4-digit common-anode 7-segment display.
- Sits directly upstream of the team's 4-bit-to-7-segment decoder: drives the decoder's 4-bit input with one digit's nibble at a time, plus the matching anode enable.
- Holds a 16-bit display value and accepts new values through a load/acknowledge handshake.
- New values take effect only at frame boundaries, so no digit ever shows a torn value.

Parameters:
- N_DIGITS, 4, number of digits scanned; nibble i = value bits [4i+3:4i].
- REFRESH_DIV, 50000, clock cycles per digit slot; must be >= 2. Prescaler width is $clog2(REFRESH_DIV).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- value_in  in  4*N_DIGITS  value to display; digit 0 is the least significant nibble.
- load  in  1  single-cycle strobe; captures value_in.
- dp_in  in  N_DIGITS  decimal-point request per digit, sampled live.
- blank_lz  in  1  enables leading-zero blanking, sampled live.
- digit_nibble  out  4  nibble for the downstream 7-segment decoder input.
- anode_n  out  N_DIGITS  active-low digit enables; at most one bit low.
- dp_n  out  1  active-low decimal point for the current digit.
- load_ack  out  1  one-cycle pulse when a loaded value becomes the displayed value.
- frame_tick  out  1  one-cycle pulse when the digit index wraps from N_DIGITS-1 to 0.

Behaviour:
- Clocking and reset
  - One clock domain. Reset is asynchronous assert and synchronous deassert; the deassert synchronizer lives at top level, not in this block.
  - Reset values: prescaler 0, digit index 0, staging 0, display 0, pending 0.
  - Output reset values: digit_nibble 0, anode_n all ones, dp_n 1, load_ack 0, frame_tick 0.
- Prescaler
  - Counts 0..REFRESH_DIV-1 and wraps.
  - slot_end is asserted when count == REFRESH_DIV-1.
- Digit index
  - Advances on slot_end and wraps N_DIGITS-1 -> 0.
  - frame_end = slot_end && index == N_DIGITS-1.
- Load FSM, two states
  - IDLE: load -> staging <= value_in, go to PENDING.
  - PENDING: load -> staging overwritten (last load wins), stay in PENDING.
  - PENDING and frame_end -> display <= staging, load_ack pulses next cycle, go to IDLE.
  - load coincident with frame_end, from either state: display <= value_in directly (bypass), staging <= value_in, load_ack pulses, go to IDLE.
  - load in IDLE without frame_end: the value waits up to one full frame (N_DIGITS*REFRESH_DIV cycles).
- Outputs
  - All outputs are registered: one cycle of latency from the internal index/display state.
  - digit_nibble = display nibble[index].
  - anode_n = ~(1 << index).
  - dp_n = ~dp_in[index].
- Leading-zero blanking
  - Applies when blank_lz = 1, index > 0, and all nibbles from index up to N_DIGITS-1 are 0.
  - When it applies: anode_n is all ones, dp_n = ~dp_in[index] still, digit_nibble is still driven.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
- Pulses
  - frame_tick is asserted in the cycle after frame_end.
  - load_ack is asserted in the cycle after the display update, coincident with frame_tick.
- Reset mid-operation: all state is cleared immediately, including a pending load; that load is lost and no ack is ever produced for it.

Decomposition:
- Package sev_seg_pkg holds:
  - N_DIGITS_DEFAULT constant.
  - typedef logic [3:0] nibble_t.
  - typedef enum {IDLE, PENDING} load_state_t.
  - Function onehot_n(index) returning the active-low anode pattern.
- One sub-module: refresh_prescaler (parameter REFRESH_DIV; ports clk, reset, slot_end). It is reusable for other scanned outputs.

Test Plan (REFRESH_DIV=4, N_DIGITS=4, frame = 16 cycles):
1. Reset then release with display 0 and blank_lz=0:
   - anode_n steps 1110, 1101, 1011, 0111, changing every 4 cycles.
   - digit_nibble stays 0.
   - frame_tick pulses every 16 cycles.
2. load with value_in=16'h1A3F mid-frame:
   - No display change until frame_end.
   - Next frame shows digit_nibble F, 3, A, 1 in slots 0..3.
   - load_ack is a single pulse aligned with frame_tick.
3. Two loads in one frame (16'h1111, then 16'h2222):
   - Only 16'h2222 is displayed.
   - Exactly one load_ack.
4. load 16'h0042 coincident with frame_end:
   - Bypass; the very next frame shows 2, 4.
   - load_ack pulses in the next cycle.
5. blank_lz=1 with display 16'h0042:
   - Digits 2 and 3 show anode_n 1111; digits 0 and 1 are lit.
   - With display 16'h0000, only digit 0 is lit.
   - dp_in=4'b1000 still drives dp_n=0 in slot 3.
6. Assert reset while PENDING:
   - Outputs return to reset values asynchronously.
   - After release, display is 0 and no load_ack occurs.
